// File: rtl/multi_adc_pkg.sv
// Shared types, default parameters and width helpers for the multi-channel ADC capture engine.
package multi_adc_pkg;

    // Capture sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PUSH  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int unsigned DEF_N_CH       = 2;
    localparam int unsigned DEF_ADC_BITS   = 12;
    localparam int unsigned DEF_FRAME_BITS = 16;
    localparam int unsigned DEF_CLK_DIV    = 4;
    localparam int unsigned DEF_CS_HIGH    = 8;
    localparam int unsigned DEF_DEPTH      = 1024;
    localparam int unsigned NFRAMES_W      = 12;

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_adc_capture_fifo.sv
// First-word-fall-through synchronous FIFO with registered head word, level and flags.
module sync_fifo #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             empty_q, full_q;
    logic             do_wr, do_rd;

    // Pointer/level update and look-ahead of the next head word.
    always_comb begin
        do_rd     = rd_en_i && !empty_q;
        do_wr     = wr_en_i && (!full_q || do_rd);
        rd_ptr_d  = rd_ptr_q + AW'(do_rd);
        wr_ptr_d  = wr_ptr_q + AW'(do_wr);
        level_d   = level_q + LW'(do_wr) - LW'(do_rd);
        rd_data_d = rd_data_q;
        if ((level_q - LW'(do_rd)) == '0) begin
            if (do_wr) begin
                rd_data_d = wr_data_i;
            end
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array, written without reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
            empty_q   <= (level_d == '0);
            full_q    <= (level_d == LW'(DEPTH));
        end
    end

    assign rd_data_o = rd_data_q;
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign level_o   = level_q;

endmodule

// File: rtl/multi_adc_capture.sv
// Capture engine: drives CS/SCLK for N_CH shared-clock serial ADCs and queues samples channel-interleaved.
module multi_adc_capture
    import multi_adc_pkg::*;
#(
    parameter int unsigned N_CH       = DEF_N_CH,
    parameter int unsigned ADC_BITS   = DEF_ADC_BITS,
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned CS_HIGH    = DEF_CS_HIGH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    mode,
    input  logic [NFRAMES_W-1:0]    n_frames,
    input  logic [N_CH-1:0]         sdo,
    output logic                    cs_n,
    output logic                    sclk,
    input  logic                    rd_en,
    output logic [ADC_BITS-1:0]     rd_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int unsigned DIV_W = cnt_w(CLK_DIV);
    localparam int unsigned BIT_W = cnt_w(FRAME_BITS);
    localparam int unsigned CH_W  = cnt_w(N_CH);
    localparam int unsigned GAP_W = cnt_w(CS_HIGH);

    state_e                        state_q, state_d;
    logic [DIV_W-1:0]              div_q, div_d;
    logic                          phase_q, phase_d;
    logic [BIT_W-1:0]              bit_q, bit_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [GAP_W-1:0]              gap_q, gap_d;
    logic [NFRAMES_W-1:0]          frame_q, frame_d;
    logic [NFRAMES_W-1:0]          nfr_q, nfr_d;
    logic                          mode_q, mode_d;
    logic                          stop_seen_q, stop_seen_d;
    logic                          ovf_q, ovf_d;
    logic                          cs_n_q, cs_n_d;
    logic                          sclk_q, sclk_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [N_CH-1:0][ADC_BITS-1:0] shreg_q, shreg_d;
    logic                          push_c;
    logic                          fifo_full;

    // Sequencer next state, counters, deserialisers and registered pin values.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        ch_d        = ch_q;
        gap_d       = gap_q;
        frame_d     = frame_q;
        nfr_d       = nfr_q;
        mode_d      = mode_q;
        stop_seen_d = stop_seen_q;
        ovf_d       = ovf_q;
        shreg_d     = shreg_q;
        done_d      = 1'b0;
        push_c      = 1'b0;

        if (state_q != ST_IDLE && stop) begin
            stop_seen_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    nfr_d       = n_frames;
                    ovf_d       = 1'b0;
                    stop_seen_d = 1'b0;
                    frame_d     = '0;
                    div_d       = '0;
                    if (!mode && n_frames == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    phase_d = !phase_q;
                    if (!phase_q) begin
                        for (int unsigned c = 0; c < N_CH; c++) begin
                            shreg_d[c] = {shreg_q[c][ADC_BITS-2:0], sdo[c]};
                        end
                    end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        ch_d    = '0;
                        state_d = ST_PUSH;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_PUSH: begin
                push_c = 1'b1;
                if (ch_q == CH_W'(N_CH - 1)) begin
                    gap_d   = '0;
                    frame_d = frame_q + NFRAMES_W'(1);
                    state_d = ST_GAP;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(CS_HIGH - 1)) begin
                    if ((!mode_q && frame_q >= nfr_q) || stop_seen_q || stop) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        div_d   = '0;
                        state_d = ST_SETUP;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A full FIFO still takes the word when the host pops in the same cycle.
        if (push_c && fifo_full && !rd_en) begin
            ovf_d = 1'b1;
        end

        cs_n_d = !(state_d == ST_SETUP || state_d == ST_SHIFT);
        sclk_d = !(state_d == ST_SHIFT && !phase_d);
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            phase_q     <= 1'b0;
            bit_q       <= '0;
            ch_q        <= '0;
            gap_q       <= '0;
            frame_q     <= '0;
            nfr_q       <= '0;
            mode_q      <= 1'b0;
            stop_seen_q <= 1'b0;
            ovf_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shreg_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            ch_q        <= ch_d;
            gap_q       <= gap_d;
            frame_q     <= frame_d;
            nfr_q       <= nfr_d;
            mode_q      <= mode_d;
            stop_seen_q <= stop_seen_d;
            ovf_q       <= ovf_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            shreg_q     <= shreg_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADC_BITS)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (push_c),
        .wr_data_i (shreg_q[ch_q]),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .empty_o   (empty),
        .full_o    (fifo_full),
        .level_o   (level)
    );

    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multi_adc_capture.sv
// Scoreboard bench for multi_adc_capture with two modelled 16-bit-frame ADCs and an 8-deep FIFO.
module tb_multi_adc_capture;

    localparam int unsigned N_CH     = 2;
    localparam int unsigned ADC_BITS = 12;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned LW       = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                mode = 1'b0;
    logic [11:0]         n_frames = '0;
    logic [N_CH-1:0]     sdo = '0;
    logic                rd_en = 1'b0;
    logic                cs_n, sclk, empty, busy, done, overflow;
    logic [ADC_BITS-1:0] rd_data;
    logic [LW-1:0]       level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cs_fall_cnt = 0;
    int first_cs_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int sclk_falls = 0;
    int adc_idx = -1;
    logic prev_cs_n = 1'b1;
    logic [15:0] adc0 = '0;
    logic [15:0] adc1 = '0;
    logic [ADC_BITS-1:0] exp_q [$];

    multi_adc_capture #(
        .N_CH  (N_CH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .n_frames (n_frames),
        .sdo      (sdo),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ADC models: next MSB-first bit driven on each SCLK fall while selected.
    always @(negedge cs_n) adc_idx = 15;
    always @(negedge sclk) begin
        if (cs_n === 1'b0 && adc_idx >= 0) begin
            sdo = {adc1[adc_idx], adc0[adc_idx]};
            adc_idx--;
            sclk_falls++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: frame/done bookkeeping and scoreboard compare on every accepted pop.
    always @(negedge clk) begin
        if (cs_n === 1'b0 && prev_cs_n === 1'b1) begin
            if (cs_fall_cnt == 0) first_cs_cyc = cyc;
            cs_fall_cnt++;
        end
        prev_cs_n = cs_n;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_en === 1'b1 && empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got %0h expected no word", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic m, input logic [11:0] n);
        start = 1'b1; mode = m; n_frames = n;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic clear_counts();
        sclk_falls = 0; cs_fall_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && done_cnt < target; i++) tick();
        check(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_cs(input int target, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && cs_fall_cnt < target; i++) tick();
        check(name, 32'(cs_fall_cnt), 32'(target));
    endtask

    task automatic drain(input string name);
        bit fin = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 64 && !fin; i++) begin
            @(negedge clk);
            if (empty) fin = 1'b1;
        end
        rd_en = 1'b0;
        tick();
        check({name, "_empty"}, 32'(empty), 32'd1);
        check({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit seen_low;
        bit found;

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Counted 3 frames; a start while busy must be ignored
        clear_counts();
        adc0 = 16'h0ABC; adc1 = 16'h0123;
        repeat (3) begin exp_q.push_back(12'hABC); exp_q.push_back(12'h123); end
        pulse_start(1'b0, 12'd3);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_cs_low", 32'(cs_n), 32'd0);
        repeat (50) tick();
        pulse_start(1'b1, 12'd5);
        wait_done(1, 700, "t1_done");
        check("t1_sclk_falls", 32'(sclk_falls), 32'd48);
        check("t1_frames", 32'(cs_fall_cnt), 32'd3);
        check("t1_done_latency", 32'(done_cyc - first_cs_cyc), 32'd426);
        @(negedge clk);
        check("t1_level", 32'(level), 32'd6);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_ovf", 32'(overflow), 32'd0);
        check("t1_head", 32'(rd_data), 32'h0ABC);
        tick();
        drain("t1");

        // Counted with zero frames
        clear_counts();
        pulse_start(1'b0, 12'd0);
        @(negedge clk);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_cs_n", 32'(cs_n), 32'd1);
        @(negedge clk);
        check("t2_done_once", 32'(done), 32'd0);
        repeat (10) tick();
        check("t2_no_frame", 32'(cs_fall_cnt), 32'd0);

        // Continuous, stop mid-SHIFT of frame 2
        clear_counts();
        adc0 = 16'hA5F0; adc1 = 16'h7C3E;
        repeat (2) begin exp_q.push_back(12'h5F0); exp_q.push_back(12'hC3E); end
        pulse_start(1'b1, 12'd0);
        wait_cs(2, 400, "t3_frame2");
        repeat (20) tick();
        pulse_stop();
        wait_done(1, 400, "t3_done");
        check("t3_sclk_falls", 32'(sclk_falls), 32'd32);
        check("t3_frames", 32'(cs_fall_cnt), 32'd2);
        check("t3_done_latency", 32'(done_cyc - first_cs_cyc), 32'd284);
        check("t3_level", 32'(level), 32'd4);
        drain("t3");

        // Overflow: fill 6, then 3 more frames into 2 free slots; stop while idle is ignored
        clear_counts();
        pulse_stop();
        adc0 = 16'h0ABC; adc1 = 16'h0123;
        repeat (3) begin exp_q.push_back(12'hABC); exp_q.push_back(12'h123); end
        pulse_start(1'b0, 12'd3);
        wait_done(1, 700, "t4a_done");
        check("t4a_frames", 32'(cs_fall_cnt), 32'd3);
        check("t4a_ovf", 32'(overflow), 32'd0);
        clear_counts();
        adc0 = 16'hF111; adc1 = 16'h8222;
        exp_q.push_back(12'h111); exp_q.push_back(12'h222);
        pulse_start(1'b0, 12'd3);
        wait_done(1, 700, "t4b_done");
        check("t4b_level", 32'(level), 32'd8);
        check("t4b_ovf", 32'(overflow), 32'd1);
        pulse_start(1'b0, 12'd0);
        @(negedge clk);
        check("t4c_ovf_clr", 32'(overflow), 32'd0);
        check("t4c_level", 32'(level), 32'd8);

        // Full FIFO, pop during both PUSH cycles
        tick();
        clear_counts();
        adc0 = 16'h1333; adc1 = 16'hE444;
        exp_q.push_back(12'h333); exp_q.push_back(12'h444);
        pulse_start(1'b0, 12'd1);
        seen_low = 1'b0; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (cs_n == 1'b0) seen_low = 1'b1;
            else if (seen_low) found = 1'b1;
        end
        check("t5_push_seen", 32'(found), 32'd1);
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        wait_done(1, 100, "t5_done");
        check("t5_level", 32'(level), 32'd8);
        check("t5_ovf", 32'(overflow), 32'd0);
        drain("t5");

        // Reset in the middle of frame 2
        clear_counts();
        adc0 = 16'h0555; adc1 = 16'h0666;
        pulse_start(1'b0, 12'd2);
        wait_cs(2, 400, "t6_frame2");
        repeat (30) tick();
        check("t6_level_pre", 32'(level), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_cs_n", 32'(cs_n), 32'd1);
        check("t6_sclk", 32'(sclk), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_level", 32'(level), 32'd0);
        repeat (400) tick();
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_idle", 32'(cs_fall_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
